// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: buffers (data, dest) words in a small FIFO and feeds
// the 1-to-8 demux one word per cycle, dropping a head word whose channel
// stays blocked for TIMEOUT consecutive cycles.
module demux_dispatch_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [2:0]               in_dest,
    input  logic [7:0]               ch_ready,
    output logic [DATA_W-1:0]        dmx_data,
    output logic [2:0]               dmx_sel,
    output logic                     dmx_en,
    output logic                     drop_pulse,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    logic [DATA_W+2:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic [TW-1:0]     timer;
    state_t            state;
    state_t            state_nxt;

    logic              push;
    logic              pop;
    logic              head_valid;
    logic              dispatch;
    logic              block;
    logic              drop;
    logic [2:0]        hd;
    logic [DATA_W-1:0] hdata;

    // A full FIFO refuses input even when it is popping this cycle (no bypass).
    assign in_ready   = !rst && (count != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign {hd, hdata} = mem[rd_ptr];
    assign fifo_count = count;

    // Storage array; pointer and occupancy reset make old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dest, in_data};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE whenever the FIFO ends up empty, WAIT while the same head stays blocked.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        state_nxt = RUN;
        if (count_nxt == '0) begin
            state_nxt = IDLE;
        end else if (block) begin
            state_nxt = WAIT;
        end
    end

    // Head evaluation: exactly one of dispatch/block/drop when a word is buffered.
    always_comb begin
        head_valid = (state != IDLE);
        dispatch   = head_valid && ch_ready[hd];
        block      = head_valid && !ch_ready[hd] && (timer != TIMER_MAX);
        drop       = head_valid && !ch_ready[hd] && (timer == TIMER_MAX);
        pop        = dispatch || drop;
    end

    // Datapath registers: pointers, occupancy, blocked-cycle timer and demux outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            timer      <= '0;
            dmx_en     <= 1'b0;
            dmx_data   <= '0;
            dmx_sel    <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nxt;
            timer      <= block ? timer + 1'b1 : '0;
            dmx_en     <= dispatch;
            dmx_data   <= dispatch ? hdata : '0;
            dmx_sel    <= dispatch ? hd : 3'd0;
            drop_pulse <= drop;
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed and random stimulus against a queue-based
// reference model; expected demux/drop events go through a scoreboard that a
// separate monitor drains whenever the DUT signals an event.
module tb_demux_dispatch_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int DATA_W  = 3;

    typedef struct {
        int         edge_no;
        logic       en;
        logic       drp;
        logic [2:0] sel;
        logic [2:0] data;
        logic [7:0] dcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_data = '0;
    logic [2:0]  in_dest = '0;
    logic [7:0]  ch_ready = 8'hFF;
    logic [2:0]  dmx_data;
    logic [2:0]  dmx_sel;
    logic        dmx_en;
    logic        drop_pulse;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_count;

    int          compared = 0;
    int          mismatched = 0;
    int          edges = 0;

    logic [5:0]  mq[$];
    exp_t        sb[$];
    int          mtimer = 0;
    int          mdrops = 0;

    demux_dispatch_ctrl #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .ch_ready  (ch_ready),
        .dmx_data  (dmx_data),
        .dmx_sel   (dmx_sel),
        .dmx_en    (dmx_en),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count),
        .fifo_count(fifo_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count rising edges so expected events can be tagged with the edge that produces them.
    always @(posedge clk) edges <= edges + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // One cycle: check registered state, drive inputs, check in_ready, advance the model.
    task automatic applyStimulus(input bit r, input bit v, input logic [2:0] d,
                                 input logic [2:0] ds, input logic [7:0] cr, output bit acc);
        bit         exp_ready;
        logic [5:0] hw;
        exp_t       e;
        @(negedge clk);
        checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
        checkOutput("drop_count", 32'(drop_count), 32'(mdrops));
        rst      = r;
        in_valid = v;
        in_data  = d;
        in_dest  = ds;
        ch_ready = cr;
        #1;
        exp_ready = !r && (mq.size() < DEPTH);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        if (r) begin
            mq.delete();
            mtimer = 0;
            mdrops = 0;
        end else begin
            if (mq.size() > 0) begin
                hw = mq[0];
                e.edge_no = edges + 1;
                if (cr[hw[5:3]]) begin
                    e.en = 1'b1; e.drp = 1'b0; e.sel = hw[5:3]; e.data = hw[2:0];
                    e.dcnt = mdrops[7:0];
                    sb.push_back(e);
                    void'(mq.pop_front());
                    mtimer = 0;
                end else if (mtimer == TIMEOUT - 1) begin
                    if (mdrops < 255) mdrops++;
                    e.en = 1'b0; e.drp = 1'b1; e.sel = '0; e.data = '0;
                    e.dcnt = mdrops[7:0];
                    sb.push_back(e);
                    void'(mq.pop_front());
                    mtimer = 0;
                end else begin
                    mtimer++;
                end
            end else begin
                mtimer = 0;
            end
            if (acc) mq.push_back({ds, d});
        end
    endtask

    // Monitor: pop and compare an expected event whenever the DUT shows one.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no < edges) begin
            checkOutput("event_edge_missed", 32'(edges), 32'(sb[0].edge_no));
            void'(sb.pop_front());
        end
        if (dmx_en || drop_pulse) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_event", {30'd0, dmx_en, drop_pulse}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_edge", 32'(edges), 32'(e.edge_no));
                checkOutput("event", {16'd0, dmx_en, drop_pulse, dmx_sel, dmx_data, drop_count},
                            {16'd0, e.en, e.drp, e.sel, e.data, e.dcnt});
            end
        end else begin
            checkOutput("idle_outputs", {26'd0, dmx_sel, dmx_data}, 32'd0);
        end
    end

    initial begin
        bit   acc;
        int   i;
        int   mode;
        int   stuck;
        logic [7:0] cr;

        // Reset.
        for (int c = 0; c < 2; c++) applyStimulus(1, 0, 0, 0, 8'hFF, acc);

        // Single word into an empty FIFO, all channels ready.
        applyStimulus(0, 1, 3'b101, 3'd3, 8'hFF, acc);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 8'hFF, acc);

        // Fill past DEPTH while blocked, then release.
        i = 0;
        for (int c = 0; c < 20; c++) begin
            cr = (c < 8) ? 8'h00 : 8'hFF;
            applyStimulus(0, i < 5, 3'(i), 3'(i), cr, acc);
            if (acc) i++;
        end

        // Dead channel 6: head dest=6 times out, dest=1 follows.
        applyStimulus(0, 1, 3'd2, 3'd6, 8'hBF, acc);
        applyStimulus(0, 1, 3'd4, 3'd1, 8'hBF, acc);
        for (int c = 0; c < 22; c++) applyStimulus(0, 0, 0, 0, 8'hBF, acc);

        // Head dest=2 blocked 10 cycles then released; next head starts a fresh timer.
        applyStimulus(0, 1, 3'd7, 3'd2, 8'h00, acc);
        applyStimulus(0, 1, 3'd3, 3'd5, 8'h00, acc);
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, 0, 0, 8'h00, acc);
        applyStimulus(0, 0, 0, 0, 8'h04, acc);
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, 8'h00, acc);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, 8'hFF, acc);

        // Three words buffered, then full-rate push/pop across pointer wrap.
        for (int c = 0; c < 3; c++) applyStimulus(0, 1, 3'(c), 3'(c + 4), 8'h00, acc);
        for (int c = 0; c < 20; c++) applyStimulus(0, 1, 3'(c), 3'(c * 3), 8'hFF, acc);
        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 0, 8'hFF, acc);

        // Reset while words are buffered and dmx_en is active.
        for (int c = 0; c < 4; c++) applyStimulus(0, 1, 3'(c + 1), 3'(c), 8'h00, acc);
        applyStimulus(0, 0, 0, 0, 8'hFF, acc);
        applyStimulus(1, 0, 0, 0, 8'hFF, acc);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 8'hFF, acc);

        // Random traffic with changing channel-availability patterns.
        mode  = 0;
        stuck = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c % 40 == 0) begin
                mode  = $urandom_range(0, 3);
                stuck = $urandom_range(0, 7);
            end
            case (mode)
                0:       cr = 8'hFF;
                1:       cr = 8'($urandom);
                2:       cr = 8'hFF & ~(8'h01 << stuck);
                default: cr = 8'($urandom) & 8'h0F;
            endcase
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                          3'($urandom), 3'($urandom), cr, acc);
        end

        // Drain and confirm every expected event was seen.
        for (int c = 0; c < 40; c++) applyStimulus(0, 0, 0, 0, 8'hFF, acc);
        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
